// File: rtl/altr_hps_mux_pkg.sv
// Shared types and helpers for the glitch-free switched N:1 mux.
// Holds the controller state encoding and the select-width derivation.
package altr_hps_mux_pkg;

    typedef enum logic {
        ACTIVE = 1'b0,
        BLANK  = 1'b1
    } mux_state_e;

    // Wide enough for the largest blanking count (255).
    localparam int CNT_W = 8;

    // Select width for n inputs, never less than one bit.
    function automatic int sel_width(input int n);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= n) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/altr_hps_muxn.sv
// Purely combinational NUM_IN:1 mux of WIDTH-bit lanes.
// Input k occupies data_in[k*WIDTH +: WIDTH]; out-of-range selects give zero.
module altr_hps_muxn
    import altr_hps_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 1,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data_out
);

    always_comb begin
        data_out = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data_out = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/altr_hps_muxn_sw.sv
// Registered N:1 mux whose select changes only through a blanking window,
// so mux_out never carries a mix of old and new inputs.
//
//   state  | meaning
//   ACTIVE | mux_out tracks mux_in[mux_sel_cur]; select requests accepted
//   BLANK  | mux_out held at IDLE_VAL while the settle counter runs down
module altr_hps_muxn_sw
    import altr_hps_mux_pkg::*;
#(
    parameter int               NUM_IN     = 4,
    parameter int               WIDTH      = 1,
    parameter int               SETTLE_CYC = 2,
    parameter logic [WIDTH-1:0] IDLE_VAL   = '0,
    parameter int               RST_SEL    = 0,
    localparam int              SEL_W      = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] mux_in,
    input  logic                    sel_req,
    input  logic [SEL_W-1:0]        sel_new,
    output logic                    sel_ack,
    output logic                    sel_err,
    output logic [SEL_W-1:0]        mux_sel_cur,
    output logic                    switching,
    output logic [WIDTH-1:0]        mux_out
);

    mux_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_cur_q, sel_cur_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             sw_q, sw_d;
    logic [WIDTH-1:0] mux_val;
    logic             req_ok;
    logic             sel_illegal;

    altr_hps_muxn #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W)
    ) u_muxn (
        .data_in  (mux_in),
        .sel      (sel_cur_q),
        .data_out (mux_val)
    );

    // A held request is not re-accepted in the cycle its response is visible.
    assign req_ok      = sel_req && !ack_q && !err_q;
    assign sel_illegal = {1'b0, sel_new} >= (SEL_W+1)'(NUM_IN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_cur_d = sel_cur_q;
        pend_d    = pend_q;
        out_d     = mux_val;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        sw_d      = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (req_ok) begin
                    if (sel_illegal) begin
                        err_d = 1'b1;
                    end else if (sel_new == sel_cur_q) begin
                        ack_d = 1'b1;
                    end else begin
                        // Blank from the accepting edge to give SETTLE_CYC+1 idle cycles.
                        pend_d  = sel_new;
                        cnt_d   = CNT_W'(SETTLE_CYC);
                        state_d = BLANK;
                        out_d   = IDLE_VAL;
                        sw_d    = 1'b1;
                    end
                end
            end
            BLANK: begin
                out_d = IDLE_VAL;
                sw_d  = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ACTIVE;
                    sel_cur_d = pend_q;
                    cnt_d     = '0;
                    ack_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACTIVE;
            cnt_q     <= '0;
            sel_cur_q <= SEL_W'(RST_SEL);
            pend_q    <= SEL_W'(RST_SEL);
            out_q     <= IDLE_VAL;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            sw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_cur_q <= sel_cur_d;
            pend_q    <= pend_d;
            out_q     <= out_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            sw_q      <= sw_d;
        end
    end

    assign sel_ack     = ack_q;
    assign sel_err     = err_q;
    assign mux_sel_cur = sel_cur_q;
    assign switching   = sw_q;
    assign mux_out     = out_q;

endmodule
